// File: rtl/noc_input_port.sv
// NoC router input port: framing check on the link side, FWFT flit FIFO,
// and a head-flit register feeding the address-calculation stage.
module noc_input_port #(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [255:0]  in_flit,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [255:0]  out_flit,
  output logic [255:0]  hf_out,
  output logic          hf_valid,
  output logic          drop_err,
  output logic          seq_err,
  output logic [15:0]   pkt_count,
  output logic          o_dbg_state,
  output logic [AW:0]   o_dbg_count
);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // valid never waits on ready, and both ready/valid here come from
  // registered count only, so there is no ready->ready combinational path.

  localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_IN_PKT = 1'b1
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;

  logic [255:0]   r_mem [DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [AW:0]    r_count;

  logic [255:0]   r_hf_out;
  logic           r_hf_valid;
  logic           r_drop_err;
  logic           r_seq_err;
  logic [15:0]    r_pkt_count;

  logic           w_full;
  logic           w_empty;
  logic           w_accept;
  logic           w_deq;
  logic           w_enq;
  logic           w_drop;
  logic           w_seq;
  logic           w_head_out;
  logic [1:0]     w_type;

  assign w_full     = (r_count == LP_DEPTH);
  assign w_empty    = (r_count == '0);
  assign in_ready   = !w_full;
  assign out_valid  = !w_empty;
  assign w_accept   = in_valid && in_ready;
  assign w_deq      = out_valid && out_ready;
  assign w_type     = in_flit[255:254];
  assign out_flit   = r_mem[r_rd_ptr];
  assign w_head_out = out_flit[254];

  // Framing: type[0] marks a packet start, type[1] marks a packet end.
  always_comb begin
    w_state_nxt = r_state;
    w_enq       = 1'b0;
    w_drop      = 1'b0;
    w_seq       = 1'b0;
    if (w_accept) begin
      case (r_state)
        ST_IDLE: begin
          if (w_type[0]) begin
            w_enq       = 1'b1;
            w_state_nxt = w_type[1] ? ST_IDLE : ST_IN_PKT;
          end else begin
            w_drop = 1'b1;
          end
        end
        ST_IN_PKT: begin
          w_enq       = 1'b1;
          w_seq       = w_type[0];
          w_state_nxt = w_type[1] ? ST_IDLE : ST_IN_PKT;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_enq) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_deq) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is deliberately not reset; out_flit is only meaningful with out_valid.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_mem[r_wr_ptr] <= in_flit;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hf_out    <= '0;
      r_hf_valid  <= 1'b0;
      r_drop_err  <= 1'b0;
      r_seq_err   <= 1'b0;
      r_pkt_count <= '0;
    end else begin
      r_hf_valid <= w_deq && w_head_out;
      r_drop_err <= w_drop;
      r_seq_err  <= w_seq;
      if (w_deq && w_head_out) begin
        r_hf_out    <= out_flit;
        r_pkt_count <= r_pkt_count + 16'd1;
      end
    end
  end

  assign hf_out      = r_hf_out;
  assign hf_valid    = r_hf_valid;
  assign drop_err    = r_drop_err;
  assign seq_err     = r_seq_err;
  assign pkt_count   = r_pkt_count;
  assign o_dbg_state = r_state;
  assign o_dbg_count = r_count;

  a_count_bound: assert property (@(posedge clk) disable iff (reset) r_count <= LP_DEPTH);
  a_no_push_full: assert property (@(posedge clk) disable iff (reset) !(w_enq && w_full));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (reset) !(w_deq && w_empty));

endmodule

// File: tb/tb_noc_input_port.sv
// Bench for noc_input_port: directed table, hand-written corner sequences and
// random traffic, all scored against a queue-based packet model.
module tb_noc_input_port;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [255:0]  in_flit = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [255:0]  out_flit;
  logic [255:0]  hf_out;
  logic          hf_valid;
  logic          drop_err;
  logic          seq_err;
  logic [15:0]   pkt_count;
  logic          o_dbg_state;
  logic [AW:0]   o_dbg_count;

  noc_input_port #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_flit(in_flit),
    .out_valid(out_valid), .out_ready(out_ready), .out_flit(out_flit),
    .hf_out(hf_out), .hf_valid(hf_valid), .drop_err(drop_err), .seq_err(seq_err),
    .pkt_count(pkt_count), .o_dbg_state(o_dbg_state), .o_dbg_count(o_dbg_count)
  );

  always #5 clk = ~clk;

  // ---------------- scoreboard / reference model ----------------
  logic [255:0] exp_q[$];
  logic         m_in_pkt;
  logic [255:0] m_hf;
  logic [15:0]  m_pkt;
  logic         m_hfv;
  int           n_tests = 0;
  int           n_fail  = 0;
  int           n_seq_seen  = 0;
  int           n_drop_seen = 0;
  logic [7:0]   hf_dests[$];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] make_flit(input logic [1:0] typ, input logic [7:0] src,
                                             input logic [7:0] dst);
    logic [255:0] f;
    for (int i = 0; i < 8; i++) f[i*32 +: 32] = $urandom;
    f[255:254] = typ;
    if (typ[0]) begin
      f[247:240] = src;
      f[239:232] = dst;
    end
    return f;
  endfunction

  task automatic model_clear();
    exp_q.delete();
    m_in_pkt = 1'b0;
    m_hf     = '0;
    m_pkt    = '0;
    m_hfv    = 1'b0;
  endtask

  // One clock cycle: drive, check combinational view, clock, update model, check registers.
  task automatic step(input logic v, input logic [255:0] f, input logic ordy);
    logic acc, deq, drop, seq;
    logic [255:0] popped;
    in_valid  = v;
    in_flit   = f;
    out_ready = ordy;
    #3;
    chk("in_ready", 256'(in_ready), 256'(exp_q.size() < DEPTH));
    chk("out_valid", 256'(out_valid), 256'(exp_q.size() > 0));
    if (exp_q.size() > 0) chk("out_flit", out_flit, exp_q[0]);
    acc = v && (exp_q.size() < DEPTH);
    deq = ordy && (exp_q.size() > 0);
    @(posedge clk);
    #1;
    m_hfv = 1'b0;
    drop  = 1'b0;
    seq   = 1'b0;
    if (deq) begin
      popped = exp_q.pop_front();
      if (popped[254]) begin
        m_hf  = popped;
        m_hfv = 1'b1;
        m_pkt = m_pkt + 16'd1;
      end
    end
    if (acc) begin
      if (m_in_pkt) begin
        exp_q.push_back(f);
        seq      = f[254];
        m_in_pkt = !f[255];
      end else if (f[254]) begin
        exp_q.push_back(f);
        m_in_pkt = !f[255];
      end else begin
        drop = 1'b1;
      end
    end
    chk("hf_valid", 256'(hf_valid), 256'(m_hfv));
    chk("hf_out", hf_out, m_hf);
    chk("drop_err", 256'(drop_err), 256'(drop));
    chk("seq_err", 256'(seq_err), 256'(seq));
    chk("pkt_count", 256'(pkt_count), 256'(m_pkt));
    chk("count", 256'(o_dbg_count), 256'(exp_q.size()));
    chk("state", 256'(o_dbg_state), 256'(m_in_pkt));
    n_seq_seen  += int'(seq_err);
    n_drop_seen += int'(drop_err);
    if (hf_valid) hf_dests.push_back(hf_out[239:232]);
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    reset     = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    model_clear();
    chk("rst_in_ready", 256'(in_ready), 256'(1));
    chk("rst_out_valid", 256'(out_valid), 256'(0));
    chk("rst_hf_out", hf_out, 256'(0));
    chk("rst_pkt_count", 256'(pkt_count), 256'(0));
    chk("rst_pulses", 256'({hf_valid, drop_err, seq_err}), 256'(0));
    chk("rst_state", 256'(o_dbg_state), 256'(0));
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic       v;
    logic [1:0] typ;
    logic [7:0] src;
    logic [7:0] dst;
    logic       ordy;
    logic       e_ov;
    logic       e_ir;
    logic       e_hfv;
    logic       e_drop;
    logic       e_seq;
  } vec_t;

  vec_t tbl[7];

  initial begin
    logic [1:0] typ;
    tbl[0] = '{1'b1, 2'b01, 8'h12, 8'h34, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 2'b00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 2'b10, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 2'b00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 2'b00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 2'b10, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 2'b00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    do_reset();
    for (int i = 0; i < 7; i++) begin
      step(tbl[i].v, make_flit(tbl[i].typ, tbl[i].src, tbl[i].dst), tbl[i].ordy);
      chk($sformatf("tbl%0d_out_valid", i), 256'(out_valid), 256'(tbl[i].e_ov));
      chk($sformatf("tbl%0d_in_ready", i), 256'(in_ready), 256'(tbl[i].e_ir));
      chk($sformatf("tbl%0d_hf_valid", i), 256'(hf_valid), 256'(tbl[i].e_hfv));
      chk($sformatf("tbl%0d_drop_err", i), 256'(drop_err), 256'(tbl[i].e_drop));
      chk($sformatf("tbl%0d_seq_err", i), 256'(seq_err), 256'(tbl[i].e_seq));
    end
    chk("tbl_hf_src_dest", 256'(hf_out[247:232]), 256'(16'h1234));
    chk("tbl_pkt_count", 256'(pkt_count), 256'(1));

    // Fill to full with the reader stalled, drain; repeat from a shifted pointer.
    do_reset();
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1) begin
        for (int i = 0; i < 3; i++) step(1'b1, make_flit(2'b11, 8'h0, 8'h0), 1'b1);
        step(1'b0, '0, 1'b1);
      end
      for (int i = 0; i < DEPTH; i++) begin
        typ = (i == 0) ? 2'b01 : ((i == DEPTH-1) ? 2'b10 : 2'b00);
        step(1'b1, make_flit(typ, 8'h55, 8'hAA), 1'b0);
      end
      chk("full_in_ready", 256'(in_ready), 256'(0));
      step(1'b1, make_flit(2'b00, 8'h0, 8'h0), 1'b0);
      step(1'b0, '0, 1'b1);
      chk("after_pop_in_ready", 256'(in_ready), 256'(1));
      for (int i = 1; i < DEPTH; i++) step(1'b0, '0, 1'b1);
      chk("drained_out_valid", 256'(out_valid), 256'(0));
    end

    // Head inside an open packet.
    do_reset();
    n_seq_seen = 0;
    hf_dests.delete();
    step(1'b1, make_flit(2'b01, 8'h0A, 8'h01), 1'b1);
    step(1'b1, make_flit(2'b00, 8'h00, 8'h00), 1'b1);
    step(1'b1, make_flit(2'b01, 8'h0B, 8'h02), 1'b1);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    chk("seq_pulses", 256'(n_seq_seen), 256'(1));
    chk("seq_hf_pulses", 256'(hf_dests.size()), 256'(2));
    if (hf_dests.size() == 2) begin
      chk("seq_hf_dest0", 256'(hf_dests[0]), 256'(8'h01));
      chk("seq_hf_dest1", 256'(hf_dests[1]), 256'(8'h02));
    end
    chk("seq_pkt_count", 256'(pkt_count), 256'(2));

    // Asynchronous reset in the middle of a packet.
    do_reset();
    step(1'b1, make_flit(2'b01, 8'h01, 8'h02), 1'b0);
    step(1'b1, make_flit(2'b00, 8'h00, 8'h00), 1'b0);
    step(1'b1, make_flit(2'b00, 8'h00, 8'h00), 1'b0);
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("arst_out_valid", 256'(out_valid), 256'(0));
    chk("arst_in_ready", 256'(in_ready), 256'(1));
    chk("arst_count", 256'(o_dbg_count), 256'(0));
    chk("arst_state", 256'(o_dbg_state), 256'(0));
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    model_clear();
    step(1'b1, make_flit(2'b00, 8'h00, 8'h00), 1'b0);
    chk("arst_body_drop", 256'(drop_err), 256'(1));
    chk("arst_body_out_valid", 256'(out_valid), 256'(0));

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, make_flit(2'($urandom_range(0, 3)),
           8'($urandom), 8'($urandom)), $urandom_range(0, 3) != 0);
    end

    // Full-rate single-flit packets across the pkt_count wrap.
    do_reset();
    n_seq_seen  = 0;
    n_drop_seen = 0;
    for (int i = 0; i < 65537; i++) step(1'b1, make_flit(2'b11, 8'h01, 8'h02), 1'b1);
    step(1'b0, '0, 1'b1);
    chk("wrap_pkt_count", 256'(pkt_count), 256'(1));
    chk("wrap_no_seq", 256'(n_seq_seen), 256'(0));
    chk("wrap_no_drop", 256'(n_drop_seen), 256'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/noc_input_port.md
# noc_input_port

Input port stage of the NoC router. Accepts 256-bit flits from the link over a valid/ready handshake and buffers them in a first-word-fall-through FIFO. Checks packet framing and forwards flits downstream. On each dequeued head flit it holds that flit in a register, `hf_out`, which drives the `HF` input of the address-calculation stage.

## Interface
Parameters:
- `DEPTH`, 8: FIFO depth in flits; power of two, minimum 2.
- `AW`, $clog2(DEPTH): pointer width. Derived; do not override.

Ports:
- `clk` in 1: clock.
- `reset` in 1: reset, asynchronous, active-high.
- `in_valid` in 1: upstream flit valid.
- `in_ready` out 1: port can accept a flit; equals !full.
- `in_flit` in 256: incoming flit. [255:254] type: 01 head, 00 body, 10 tail, 11 head+tail (single-flit packet). Head only: [247:240] src, [239:232] dest.
- `out_valid` out 1: FIFO non-empty.
- `out_ready` in 1: downstream accepts the flit.
- `out_flit` out 256: FIFO head entry (FWFT).
- `hf_out` out 256: last dequeued head flit; feeds the address calculator's `HF`.
- `hf_valid` out 1: one-cycle pulse; `hf_out` was updated on the previous edge.
- `drop_err` out 1: one-cycle pulse; a body/tail flit arrived outside a packet and was dropped.
- `seq_err` out 1: one-cycle pulse; a head flit arrived inside an open packet.
- `pkt_count` out 16: count of head flits dequeued; wraps modulo 2^16.

## Operation
- Accept condition: `in_valid && in_ready`.
- Framing FSM is evaluated on accepted flits only. It has two states, IDLE and IN_PKT; reset state is IDLE.
- IDLE + head (01): enqueue; go to IN_PKT.
- IDLE + head+tail (11): enqueue; stay IDLE.
- IDLE + body or tail: do not enqueue; flit is consumed (handshake completes); `drop_err` pulses next cycle; stay IDLE.
- IN_PKT + body: enqueue; stay IN_PKT.
- IN_PKT + tail: enqueue; go to IDLE.
- IN_PKT + head: enqueue; `seq_err` pulses next cycle; stay IN_PKT. The old packet is considered truncated.
- IN_PKT + head+tail: enqueue; `seq_err` pulses; go to IDLE.
- FIFO uses a circular buffer. `wr_ptr`/`rd_ptr` are AW bits and wrap from DEPTH-1 to 0. `count` is AW+1 bits. full = (count == DEPTH); empty = (count == 0).
- Dequeue condition: `out_valid && out_ready`. If the dequeued flit's type[0] = 1 (head or head+tail):
  - `hf_out` <= `out_flit`;
  - `hf_valid` = 1 next cycle;
  - `pkt_count` increments.
- Simultaneous enqueue and dequeue leaves `count` unchanged. A push while full cannot occur because `in_ready` = 0. A pop while empty cannot occur because `out_valid` = 0.
- A dropped flit with a simultaneous pop decrements `count`.
- Reset values:
  - `count`, `wr_ptr`, `rd_ptr`, `pkt_count` = 0.
  - `hf_out` = 0; `hf_valid`, `drop_err`, `seq_err` = 0.
  - FSM = IDLE.
  - Therefore `out_valid` = 0 and `in_ready` = 1.
  - FIFO storage is not reset; `out_flit` is don't-care while `out_valid` = 0.
- Reset mid-packet discards all buffered flits and the open packet. After reset, the first body/tail is dropped with `drop_err`.

## Timing
- `in_ready` and `out_valid` are combinational from registered `count` only. There is no combinational path from `out_ready` to `in_ready`, so a full FIFO accepts again one cycle after a pop.
- Enqueue at edge N: `out_valid` is high after edge N, and the flit is visible on `out_flit` in cycle N+1. Minimum latency is 1 cycle.
- Head flit dequeued at edge M:
  - `hf_out` is valid after edge M;
  - `hf_valid` is high in cycle M+1 only;
  - the address calculator registers `src_addr`/`dest_addr` at edge M+1.
- Error pulses are registered, high for exactly one cycle after the offending accept edge.
- Full-rate throughput: one flit per cycle when `out_ready` is held high.

## Test plan
- After reset: `in_ready`=1, `out_valid`=0, `hf_out`=0, `pkt_count`=0. Push head with [247:240]=8'h12, [239:232]=8'h34, then body, then tail, with `out_ready`=1. Flits emerge in order one cycle after each push. `hf_valid` pulses once; `hf_out`[247:232]=16'h1234; `pkt_count`=1.
- `out_ready`=0; push DEPTH flits (head, DEPTH-2 bodies, tail). `in_ready` drops after the 8th push with DEPTH=8. Release `out_ready`: all 8 flits drain in order, and `in_ready` returns 1 the cycle after the first pop. Pointer wrap is verified across a second fill.
- From IDLE, push a body then a tail. Both are consumed; `drop_err` pulses twice; `out_valid` stays 0.
- Push head A (dest 8'h01), body, then head B (dest 8'h02) without a tail. `seq_err` pulses once; all three flits are forwarded. Two `hf_valid` pulses occur with dest 8'h01 then 8'h02; `pkt_count`=2.
- Push 3 flits of a packet, assert `reset` asynchronously mid-cycle. `out_valid`=0 immediately; `count`=0; FSM is IDLE. A following body is dropped with `drop_err`.
- Stream 65537 head+tail flits at full rate. `pkt_count` wraps to 1; `seq_err` and `drop_err` never assert.
